// File: rtl/sb_mem_slave.sv
// sb bus memory slave: DEPTH x 32-bit array behind an IDLE/WAIT/ACK handshake.
// Define SB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states before each acknowledge.
module sb_mem_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_req,
    input  logic        s_rw,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_byte_mask,
    output logic [31:0] s_rdata_o,
    output logic        s_ack_o,
    output logic        s_err_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0 ||
        WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_cfg
        $error("sb_mem_slave: DEPTH must be a power of two in 16..4096, WAIT_CYCLES in 0..15");
    end

`ifdef SB_SLAVE_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_e;
    logic [3:0]  cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd2} state_e;
`endif

    state_e      state_q, state_d;
    logic        rw_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  mask_q;
    logic        enter_ack;

    logic [31:0] mem [DEPTH];

    // In IDLE the request fields are still on the bus; a zero-wait transfer
    // commits on the same edge that latches them, so use the live inputs there.
    logic          in_idle;
    logic          cur_rw;
    logic [31:0]   cur_addr, cur_wdata;
    logic [3:0]    cur_mask;
    logic          cur_err;
    logic [AW-1:0] cur_idx;

    assign in_idle   = (state_q == IDLE);
    assign cur_rw    = in_idle ? s_rw        : rw_q;
    assign cur_addr  = in_idle ? s_addr      : addr_q;
    assign cur_wdata = in_idle ? s_wdata     : wdata_q;
    assign cur_mask  = in_idle ? s_byte_mask : mask_q;
    assign cur_err   = (cur_addr[1:0] != 2'b00) || (cur_addr[31:AW+2] != '0);
    assign cur_idx   = cur_addr[AW+1:2];

    always_comb begin
        state_d   = state_q;
        enter_ack = 1'b0;
`ifdef SB_SLAVE_WAIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_req) begin
`ifdef SB_SLAVE_WAIT_EN
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end else begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end
`else
                    state_d   = ACK;
                    enter_ack = 1'b1;
`endif
                end
            end
`ifdef SB_SLAVE_WAIT_EN
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end
            end
`endif
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            rdata_q <= 32'h0;
`ifdef SB_SLAVE_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef SB_SLAVE_WAIT_EN
            cnt_q   <= cnt_d;
`endif
            if (in_idle && s_req) begin
                rw_q    <= s_rw;
                addr_q  <= s_addr;
                wdata_q <= s_wdata;
                mask_q  <= s_byte_mask;
            end
            if (enter_ack && !cur_rw && !cur_err)
                rdata_q <= mem[cur_idx];
        end
    end

    // Array is never reset; the rst term keeps a request seen during reset from writing.
    always_ff @(posedge clk) begin
        if (rst && enter_ack && cur_rw && !cur_err) begin
            for (int b = 0; b < 4; b++)
                if (cur_mask[b])
                    mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
    end

    assign s_ack_o   = (state_q == ACK);
    assign s_err_o   = (state_q == ACK) && cur_err;
    assign s_rdata_o = rdata_q;

endmodule

// File: tb/tb_sb_mem_slave.sv
// Self-checking bench for sb_mem_slave: directed table, corner sequences and
// randomized transfers against a word-array reference model.
module tb_sb_mem_slave;

    localparam int DEPTH = 64;
`ifdef SB_SLAVE_WAIT_EN
    localparam int WC  = 2;
    localparam int LAT = WC + 1;
`else
    localparam int WC  = 5;
    localparam int LAT = 1;
`endif

    logic        clk, rst, s_req, s_rw;
    logic [31:0] s_addr, s_wdata, s_rdata_o;
    logic [3:0]  s_byte_mask;
    logic        s_ack_o, s_err_o;

    int checks = 0;
    int errors = 0;

    sb_mem_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .s_req(s_req), .s_rw(s_rw), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_byte_mask(s_byte_mask), .s_rdata_o(s_rdata_o),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] mdl_rd;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: error if misaligned or beyond the array; else byte-masked write / word read.
    task automatic mdl_apply(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, output logic exp_err);
        longint unsigned a;
        int idx;
        a = longint'(addr);
        exp_err = (addr % 4 != 0) || (a >= 4 * DEPTH);
        if (!exp_err) begin
            idx = int'(addr / 4);
            if (rw) begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) mdl_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                mdl_rd = mdl_mem[idx];
            end
        end
    endtask

    task automatic txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, output logic [31:0] rd, output logic err,
                       output int lat);
        @(negedge clk);
        s_req = 1'b1; s_rw = rw; s_addr = addr; s_wdata = wdata; s_byte_mask = mask;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            #1;
            if (s_ack_o) begin
                lat = n;
                break;
            end
            chk("err_outside_ack", {31'h0, s_err_o}, 32'h0);
            @(posedge clk);
        end
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL ack_timeout actual=no_ack required=ack_within_40");
        end
        rd = s_rdata_o;
        err = s_err_o;
        s_req = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_single_cycle", {31'h0, s_ack_o}, 32'h0);
        chk("err_after_ack", {31'h0, s_err_o}, 32'h0);
    endtask

    task automatic run_checked(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] mask);
        logic [31:0] rd;
        logic err, exp_err;
        int lat;
        txn(rw, addr, wdata, mask, rd, err, lat);
        mdl_apply(rw, addr, wdata, mask, exp_err);
        chk("rand_latency", lat, LAT);
        chk("rand_err", {31'h0, err}, {31'h0, exp_err});
        chk("rand_rdata", rd, mdl_rd);
    endtask

    initial begin
        vec_t tbl [12];
        logic [31:0] rd, old, a;
        logic err, e;
        int lat, r;
        int ack_cyc[$];

        rst = 1'b0; s_req = 1'b0; s_rw = 1'b0; s_addr = '0; s_wdata = '0; s_byte_mask = '0;
        mdl_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", {31'h0, s_ack_o}, 32'h0);
        chk("reset_err", {31'h0, s_err_o}, 32'h0);
        chk("reset_rdata", s_rdata_o, 32'h0);
        @(negedge clk) rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_no_ack", {31'h0, s_ack_o}, 32'h0);
        end

        for (int i = 0; i < DEPTH; i++)
            run_checked(1'b1, 32'(i * 4), $urandom, 4'hF);

        tbl[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,        32'h0,        4'b0000, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,        32'h11223344, 4'b0101, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b0, 32'h10,        32'h0,        4'b0000, 1'b1, 32'hDE22BE44, 1'b0};
        tbl[4]  = '{1'b0, 32'h13,        32'h0,        4'b0000, 1'b1, 32'hDE22BE44, 1'b1};
        tbl[5]  = '{1'b0, 32'(4*DEPTH),  32'h0,        4'b0000, 1'b1, 32'hDE22BE44, 1'b1};
        tbl[6]  = '{1'b1, 32'h10,        32'hFFFFFFFF, 4'b0000, 1'b1, 32'hDE22BE44, 1'b0};
        tbl[7]  = '{1'b0, 32'h10,        32'h0,        4'b0000, 1'b1, 32'hDE22BE44, 1'b0};
        tbl[8]  = '{1'b1, 32'h11,        32'h00000000, 4'b1111, 1'b1, 32'hDE22BE44, 1'b1};
        tbl[9]  = '{1'b1, 32'(4*DEPTH+16), 32'h0,      4'b1111, 1'b1, 32'hDE22BE44, 1'b1};
        tbl[10] = '{1'b0, 32'h10,        32'h0,        4'b0000, 1'b1, 32'hDE22BE44, 1'b0};
        tbl[11] = '{1'b0, 32'hFFFFFFFC,  32'h0,        4'b0000, 1'b1, 32'hDE22BE44, 1'b1};
        for (int i = 0; i < 12; i++) begin
            txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].mask, rd, err, lat);
            mdl_apply(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].mask, e);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = 32'(4 * DEPTH + $urandom_range(0, 255) * 4);
            else             a = $urandom;
            run_checked(1'($urandom), a, $urandom, 4'($urandom));
        end

        old = mdl_mem[8];
        @(negedge clk);
        s_req = 1'b1; s_rw = 1'b1; s_addr = 32'h20; s_wdata = 32'h55AA55AA; s_byte_mask = 4'hF;
        @(posedge clk);
        #1;
`ifdef SB_SLAVE_WAIT_EN
        chk("abort_in_wait_no_ack", {31'h0, s_ack_o}, 32'h0);
`else
        chk("abort_in_ack_ack_high", {31'h0, s_ack_o}, 32'h1);
        mdl_mem[8] = 32'h55AA55AA;
`endif
        rst = 1'b0; s_req = 1'b0;
        #1;
        chk("abort_async_ack", {31'h0, s_ack_o}, 32'h0);
        chk("abort_async_err", {31'h0, s_err_o}, 32'h0);
        chk("abort_async_rdata", s_rdata_o, 32'h0);
        mdl_rd = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_ack_in_reset", {31'h0, s_ack_o}, 32'h0);
        end
        @(negedge clk) rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_ack_after", {31'h0, s_ack_o}, 32'h0);
        end
        run_checked(1'b0, 32'h20, 32'h0, 4'h0);
`ifdef SB_SLAVE_WAIT_EN
        chk("abort_old_contents", mdl_rd, old);
`else
        chk("ack_write_committed", mdl_rd, 32'h55AA55AA);
`endif

        @(negedge clk);
        s_req = 1'b1; s_rw = 1'b0; s_addr = 32'h10; s_byte_mask = 4'h0;
        for (int c = 0; c < 4 * (LAT + 1) + 10; c++) begin
            @(posedge clk); #1;
            if (s_ack_o) begin
                ack_cyc.push_back(c);
                chk("b2b_rdata", s_rdata_o, mdl_mem[4]);
                chk("b2b_err", {31'h0, s_err_o}, 32'h0);
                if (ack_cyc.size() == 4) s_req = 1'b0;
            end
        end
        s_req = 1'b0;
        mdl_rd = mdl_mem[4];
        chk("b2b_ack_count", ack_cyc.size(), 4);
        if (ack_cyc.size() >= 4) begin
            chk("b2b_first_ack", ack_cyc[0], LAT - 1);
            for (int k = 1; k < 4; k++)
                chk($sformatf("b2b_spacing%0d", k), ack_cyc[k] - ack_cyc[k-1], LAT + 1);
        end

        run_checked(1'b0, 32'h10, 32'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
